// File: rtl/binary_decoder8.sv
// 3-to-8 one-hot decoder with a combinational output and a registered copy.
// The registered copy clears asynchronously to the all-zero "no selection" state.
module binary_decoder8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] d,
  output logic [7:0] y,
  output logic [7:0] y_q
);

  // Unknown codes decode to all-X so a bad select never looks like a valid one.
  function automatic logic [7:0] decode3(input logic [2:0] code);
    logic [7:0] word;
    case (code)
      3'd0:    word = 8'h01;
      3'd1:    word = 8'h02;
      3'd2:    word = 8'h04;
      3'd3:    word = 8'h08;
      3'd4:    word = 8'h10;
      3'd5:    word = 8'h20;
      3'd6:    word = 8'h40;
      3'd7:    word = 8'h80;
      default: word = 8'bxxxx_xxxx;
    endcase
    return word;
  endfunction

  // Combinational decode, independent of clock and reset.
  always_comb begin
    y = decode3(d);
  end

  // Registered copy of the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 8'h00;
    end else begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_binary_decoder8.sv
// Directed self-checking bench for binary_decoder8: combinational decode,
// registered latency, asynchronous reset behaviour and unknown-input handling.
module tb_binary_decoder8;

  logic       clk;
  logic       rst_n;
  logic [2:0] d;
  logic [7:0] y;
  logic [7:0] y_q;

  int errors = 0;
  int checks = 0;

  binary_decoder8 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d),
    .y    (y),
    .y_q  (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0] sweep_exp [8];
  logic [2:0] rev_d     [4];
  logic [7:0] rev_exp   [4];
  logic [7:0] unk_exp;

  initial begin
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rev_d     = '{3'd7, 3'd0, 3'd5, 3'd2};
    rev_exp   = '{8'h80, 8'h01, 8'h20, 8'h04};

    rst_n = 1'b0;
    d     = 3'd0;
    #1;
    chk("reset_yq", y_q, 8'h00);

    // Exhaustive sweep, held in reset: y must still decode, y_q must stay clear
    for (int i = 0; i < 8; i++) begin
      d = 3'(i);
      #10;
      chk($sformatf("sweep_y_d%0d", i), y, sweep_exp[i]);
      chk($sformatf("sweep_onehot_d%0d", i), 8'($countones(y)), 8'd1);
    end
    chk("reset_hold_yq", y_q, 8'h00);

    for (int i = 0; i < 4; i++) begin
      d = rev_d[i];
      #10;
      chk($sformatf("reorder_y_%0d", i), y, rev_exp[i]);
    end

    // Registered latency
    @(negedge clk);
    rst_n = 1'b1;
    d     = 3'd3;
    #1;
    chk("pre_edge_yq", y_q, 8'h00);
    @(posedge clk);
    #1;
    chk("lat_yq_3", y_q, 8'h08);
    @(negedge clk);
    d = 3'd6;
    #1;
    chk("lat_hold_yq", y_q, 8'h08);
    chk("lat_y_6", y, 8'h40);
    @(posedge clk);
    #1;
    chk("lat_yq_6", y_q, 8'h40);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_yq", y_q, 8'h00);
    chk("async_rst_y", y, 8'h40);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold3_yq", y_q, 8'h00);

    // Reset release
    @(negedge clk);
    d     = 3'd1;
    rst_n = 1'b1;
    #1;
    chk("release_pre_yq", y_q, 8'h00);
    chk("release_y", y, 8'h02);
    @(posedge clk);
    #1;
    chk("release_post_yq", y_q, 8'h02);

    // d changing every cycle: y_q lags by one edge
    @(negedge clk);
    d = 3'd5;
    @(posedge clk);
    #1;
    chk("stream_yq_5", y_q, 8'h20);
    @(negedge clk);
    d = 3'd0;
    #1;
    chk("stream_hold_yq", y_q, 8'h20);
    @(posedge clk);
    #1;
    chk("stream_yq_0", y_q, 8'h01);

    // Unknown input; a two-state simulator resolves the X bits, so the
    // expectation follows the value d actually holds
    @(negedge clk);
    d = 3'bx1x;
    #1;
    if ($isunknown(d)) unk_exp = 8'bxxxx_xxxx;
    else               unk_exp = 8'h01 << d;
    chk("unknown_y", y, unk_exp);
    d = 3'd4;
    #1;
    chk("after_unknown_y", y, 8'h10);
    @(posedge clk);
    #1;
    chk("after_unknown_yq", y_q, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_decoder8.md
# binary_decoder8

3-to-8 one-hot binary decoder. Converts a 3-bit binary code `d` into an 8-bit one-hot word `y`, with exactly bit `y[d]` high. The primary output is purely combinational for use as a select or enable generator in datapath and bus-address logic. A registered copy of the decode is provided for synchronous consumers and is cleared by the asynchronous active-low reset.

## Interface
- Parameters: none. Widths are fixed at 3 bits in and 8 bits out.
- `clk`  input  1  — single system clock, rising-edge active; clocks only the registered output.
- `rst_n`  input  1  — One clock; reset is asynchronous and active-low. It clears `y_q` only and has no effect on the combinational `y`.
- `d`  input  3  — binary code to decode, unsigned, range 0..7.
- `y`  output  8  — combinational one-hot decode of `d`. `y[i] = 1` iff `d == i`.
- `y_q`  output  8  — registered copy of `y`, updated on each rising `clk`.

## Operation
- Decode function:
  - `y = 8'b1 << d`.
  - Mapping: d=0 → 0000_0001, d=1 → 0000_0010, d=2 → 0000_0100, d=3 → 0000_1000, d=4 → 0001_0000, d=5 → 0010_0000, d=6 → 0100_0000, d=7 → 1000_0000.
- Output invariants:
  - For every valid `d`, exactly one bit of `y` is 1 and all others are 0.
  - `y` is never all-zero and never multi-hot for known inputs.
- X/Z handling:
  - If any bit of `d` is X/Z, `y` must be all-X in simulation. It must not silently decode to a valid one-hot value.
  - Use a case with a default assigning `'x` for simulation. Synthesis may treat the default as don't-care.
- Combinational path:
  - `y` is independent of `clk` and `rst_n`.
  - `y` is valid whenever `d` is stable, including while `rst_n` is asserted.
- Registered path:
  - On `rst_n` falling, `y_q` becomes 8'h00 immediately, without waiting for a clock edge.
  - While `rst_n = 0`, `y_q` holds 8'h00.
  - On each rising `clk` with `rst_n = 1`, `y_q` loads the current `y`.
  - After reset, `y_q` is the only output allowed to be all-zero; it is the "no selection" state.
- Reset release:
  - The first rising `clk` after `rst_n` goes high loads `y_q` normally.
  - No extra synchronisation stage is inside this block; reset-release synchronisation is the integrator's job.
- No internal state other than the 8 flops of `y_q`. No FSM.

## Timing
- `y`: zero-cycle latency, purely combinational from `d`. Settles within one gate-level decode delay.
- `y_q`: one-cycle latency. The value at edge N+1 reflects `d` sampled at edge N.
- Reset values:
  - `y_q` = 8'h00, asynchronous.
  - `y` is not reset; it follows `d`.
- Reset mid-operation: asserting `rst_n` between edges clears `y_q` at once, while `y` continues to track `d`.
- `d` changing every cycle:
  - `y_q` follows with one-cycle lag.
  - No glitch requirement on `y`; consumers sample it synchronously or through `y_q`.

## Test plan
- Exhaustive combinational sweep: drive `d` = 0..7 in order, waiting 10 time units each. Check `y` = 8'h01, 02, 04, 08, 10, 20, 40, 80 respectively, and that `$countones(y) == 1` every step.
- Reverse/random order: drive `d` = 7, 0, 5, 2. Expect `y` = 8'h80, 01, 20, 04, with no dependence on the previous value.
- Registered latency:
  - With `rst_n = 1`, drive `d` = 3 before an edge → `y_q` = 8'h08 after that edge.
  - Change `d` to 6 → `y_q` stays 8'h08 until the next edge, then becomes 8'h40.
- Asynchronous reset mid-cycle:
  - With `y_q` = 8'h40, drop `rst_n` between edges → `y_q` = 8'h00 immediately, while `y` still equals 8'h40.
  - Hold reset over 3 edges → `y_q` stays 8'h00.
- Reset release: raise `rst_n` with `d` = 1 → `y_q` = 8'h00 until the next rising edge, then 8'h02.
- Unknown input: drive `d` = 3'bx1x → `y` is all-X. Then drive `d` = 4 → `y` = 8'h10.
